// File: rtl/accum_pkg.sv
// accum_pkg -- shared constants and helpers for the accum_n block.
//   ACC_MODE_WRAP / ACC_MODE_SAT : values for the SATURATE parameter.
//   clog2(value)                 : ceil(log2(value)), 0 for value <= 1.
//   chan_width(channels)         : channel index width, never below 1 bit.
package accum_pkg;

  localparam int ACC_MODE_WRAP = 0;
  localparam int ACC_MODE_SAT  = 1;

  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

  function automatic int chan_width(input int channels);
    return (clog2(channels) < 1) ? 1 : clog2(channels);
  endfunction

endpackage

// File: rtl/accum_satadd.sv
// accum_satadd -- combinational signed adder with overflow detect and
// optional clamp to the signed ACC_WIDTH range.
//   i_a, i_b : signed operands, already ACC_WIDTH wide
//   o_sum    : wrapped sum, or clamped sum when SATURATE == ACC_MODE_SAT
//   o_ovf    : signed overflow of this add (operands agree in sign, sum differs)
module accum_satadd
  import accum_pkg::*;
#(
  parameter int ACC_WIDTH = 32,
  parameter int SATURATE  = ACC_MODE_WRAP
) (
  input  logic [ACC_WIDTH-1:0] i_a,
  input  logic [ACC_WIDTH-1:0] i_b,
  output logic [ACC_WIDTH-1:0] o_sum,
  output logic                 o_ovf
);

  localparam logic [ACC_WIDTH-1:0] SAT_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
  localparam logic [ACC_WIDTH-1:0] SAT_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

  logic [ACC_WIDTH-1:0] w_raw;

  assign w_raw = i_a + i_b;
  assign o_ovf = (i_a[ACC_WIDTH-1] == i_b[ACC_WIDTH-1]) &&
                 (w_raw[ACC_WIDTH-1] != i_a[ACC_WIDTH-1]);

  // On overflow both operands share a sign, so i_a's sign picks the rail.
  always_comb begin
    o_sum = w_raw;
    if ((SATURATE == ACC_MODE_SAT) && o_ovf) begin
      o_sum = i_a[ACC_WIDTH-1] ? SAT_MIN : SAT_MAX;
    end
  end

endmodule

// File: rtl/accum_n.sv
// accum_n -- CHANNELS independent time-multiplexed signed accumulators.
//   clock        : rising-edge clock
//   aclr_n       : asynchronous active-low clear of all state
//   clken        : sample qualifier; nothing changes while low
//   data         : signed IN_WIDTH sample, sign-extended before adding
//   chan         : channel of data; values >= CHANNELS are ignored
//   dump         : with clken, emit channel total (including this sample)
//                  and restart that channel at zero
//   result       : dumped signed total
//   result_chan  : channel of result
//   result_valid : strobe for result/result_chan/result_ovf
//   result_ovf   : channel overflowed at least once since its last restart
//
// Output protocol: there is no backpressure. result_valid is high for exactly
// the one cycle after each accepted dump (clken=1, valid chan, dump=1); the
// qualified outputs hold their last values when result_valid is low.
module accum_n
  import accum_pkg::*;
#(
  parameter int ACC_WIDTH = 32,
  parameter int IN_WIDTH  = 16,
  parameter int CHANNELS  = 4,
  parameter int SATURATE  = ACC_MODE_WRAP
) (
  input  logic                            clock,
  input  logic                            aclr_n,
  input  logic                            clken,
  input  logic [IN_WIDTH-1:0]             data,
  input  logic [chan_width(CHANNELS)-1:0] chan,
  input  logic                            dump,
  output logic [ACC_WIDTH-1:0]            result,
  output logic [chan_width(CHANNELS)-1:0] result_chan,
  output logic                            result_valid,
  output logic                            result_ovf
);

  localparam int CW = chan_width(CHANNELS);
  // One extra bit so CHANNELS itself is representable for the range test.
  localparam logic [CW:0] CH_LIMIT = (CW+1)'(CHANNELS);

  // Register array rather than memory: reset must clear every entry.
  logic [ACC_WIDTH-1:0] r_acc [CHANNELS];
  logic                 r_ovf [CHANNELS];

  logic [ACC_WIDTH-1:0] r_result;
  logic [CW-1:0]        r_result_chan;
  logic                 r_result_valid;
  logic                 r_result_ovf;

  logic                 w_chan_ok;
  logic                 w_take;
  logic [ACC_WIDTH-1:0] w_acc_sel;
  logic                 w_ovf_sel;
  logic [ACC_WIDTH-1:0] w_data_ext;
  logic [ACC_WIDTH-1:0] w_sum;
  logic                 w_add_ovf;

  assign w_chan_ok  = ({1'b0, chan} < CH_LIMIT);
  assign w_take     = clken && w_chan_ok;
  assign w_data_ext = ACC_WIDTH'($signed(data));

  // Read the addressed channel; the add sees the value written on the
  // previous edge, so back-to-back samples to one channel need no bypass.
  always_comb begin
    w_acc_sel = '0;
    w_ovf_sel = 1'b0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (chan == CW'(i)) begin
        w_acc_sel = r_acc[i];
        w_ovf_sel = r_ovf[i];
      end
    end
  end

  accum_satadd #(
    .ACC_WIDTH (ACC_WIDTH),
    .SATURATE  (SATURATE)
  ) u_satadd (
    .i_a   (w_acc_sel),
    .i_b   (w_data_ext),
    .o_sum (w_sum),
    .o_ovf (w_add_ovf)
  );

  always_ff @(posedge clock or negedge aclr_n) begin
    if (!aclr_n) begin
      for (int i = 0; i < CHANNELS; i++) begin
        r_acc[i] <= '0;
        r_ovf[i] <= 1'b0;
      end
      r_result       <= '0;
      r_result_chan  <= '0;
      r_result_valid <= 1'b0;
      r_result_ovf   <= 1'b0;
    end else begin
      r_result_valid <= 1'b0;
      if (w_take) begin
        for (int i = 0; i < CHANNELS; i++) begin
          if (chan == CW'(i)) begin
            if (dump) begin
              r_acc[i] <= '0;
              r_ovf[i] <= 1'b0;
            end else begin
              r_acc[i] <= w_sum;
              r_ovf[i] <= r_ovf[i] | w_add_ovf;
            end
          end
        end
        if (dump) begin
          r_result       <= w_sum;
          r_result_chan  <= chan;
          r_result_valid <= 1'b1;
          r_result_ovf   <= w_ovf_sel | w_add_ovf;
        end
      end
    end
  end

  assign result       = r_result;
  assign result_chan  = r_result_chan;
  assign result_valid = r_result_valid;
  assign result_ovf   = r_result_ovf;

endmodule
